// File: rtl/lfo_pkg.sv
// lfo_pkg: shared types and constants for the lfo_sched engine.
//   - lfo_state_e   : sweep FSM states
//   - Def*          : default sample/phase/ROM widths
//   - quarter_off() : quarter-period index offset, 2^(lut_bits-2)
//   - rom_entry()   : signed sine table entry, round(sin(2*pi*i/2^lut_bits) * (2^(width-1)-1))
package lfo_pkg;

   typedef enum logic [1:0] {StIdle, StLookup, StOutput} lfo_state_e;

   localparam int unsigned DefWidth      = 8;
   localparam int unsigned DefPhaseWidth = 16;
   localparam int unsigned DefLutBits    = 8;

   function automatic int unsigned quarter_off(input int unsigned lut_bits);
      return 1 << (lut_bits - 2);
   endfunction

   // Taylor series; only ever called on [0, pi/2] so 10 terms are far beyond rounding precision.
   function automatic real sin_first_quadrant(input real x);
      real term;
      real acc;
      term = x;
      acc  = x;
      for (int k = 1; k <= 10; k++) begin
         term = -term * x * x / real'((2 * k) * (2 * k + 1));
         acc  = acc + term;
      end
      return acc;
   endfunction

   // Built from a first-quadrant value plus mirroring, so the table is exactly odd-symmetric and
   // the quarter-wave ROM variant reproduces it bit for bit.
   function automatic int rom_entry(input int unsigned idx, input int unsigned lut_bits,
                                    input int unsigned width);
      int unsigned qn;
      int unsigned quad;
      int unsigned r;
      int unsigned a;
      real         amp;
      real         v;
      int          mag;
      qn   = quarter_off(lut_bits);
      quad = (idx / qn) % 4;
      r    = idx % qn;
      a    = quad[0] ? (qn - r) : r;
      amp  = real'((1 << (width - 1)) - 1);
      v    = sin_first_quadrant(real'(a) * 3.14159265358979323846 / real'(2 * qn)) * amp;
      mag  = $rtoi(v + 0.5);
      return quad[1] ? -mag : mag;
   endfunction

endpackage

// File: rtl/lfo_sine_rom.sv
// lfo_sine_rom: registered dual-read sine/cosine lookup, one cycle latency.
//   clk, rst : clock, synchronous active-high reset (outputs cleared to 0)
//   en_i     : load a new sin/cos pair; outputs hold while low
//   idx_i    : table index; cosine reads idx_i + quarter period
//   sin_o    : registered signed sine
//   cos_o    : registered signed cosine
// Build option LFO_QUARTER_WAVE_EN: store only 2^(LUT_BITS-2)+1 entries and rebuild the other
// quadrants by mirroring and negation (requires LUT_BITS >= 3). Default: full table.
module lfo_sine_rom
   import lfo_pkg::*;
#(
   parameter int unsigned WIDTH    = DefWidth,
   parameter int unsigned LUT_BITS = DefLutBits
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       en_i,
   input  logic [LUT_BITS-1:0]        idx_i,
   output logic signed [WIDTH-1:0]    sin_o,
   output logic signed [WIDTH-1:0]    cos_o
);

   localparam int unsigned N  = 1 << LUT_BITS;
   localparam int unsigned QN = quarter_off(LUT_BITS);

   logic [LUT_BITS-1:0]     cos_idx;
   logic signed [WIDTH-1:0] sin_d, cos_d;
   logic signed [WIDTH-1:0] sin_q, cos_q;

   // Modulo-2^LUT_BITS wrap comes for free from the index width.
   assign cos_idx = idx_i + LUT_BITS'(QN);

`ifdef LFO_QUARTER_WAVE_EN
   localparam int unsigned QA = LUT_BITS - 1;

   logic signed [WIDTH-1:0] qtbl [QN+1];

   for (genvar i = 0; i <= QN; i++) begin : g_qtbl
      assign qtbl[i] = WIDTH'(rom_entry(i, LUT_BITS, WIDTH));
   end

   // Odd quadrants read the quarter table backwards; the upper half is the negated lower half.
   function automatic logic signed [WIDTH-1:0] qw_read(input logic [LUT_BITS-1:0] i);
      logic [QA-1:0]           addr;
      logic signed [WIDTH-1:0] mag;
      addr = i[LUT_BITS-2] ? (QA'(QN) - QA'(i[LUT_BITS-3:0])) : QA'(i[LUT_BITS-3:0]);
      mag  = qtbl[addr];
      return i[LUT_BITS-1] ? -mag : mag;
   endfunction

   always_comb begin
      sin_d = qw_read(idx_i);
      cos_d = qw_read(cos_idx);
   end
`else
   logic signed [WIDTH-1:0] tbl [N];

   for (genvar i = 0; i < N; i++) begin : g_tbl
      assign tbl[i] = WIDTH'(rom_entry(i, LUT_BITS, WIDTH));
   end

   always_comb begin
      sin_d = tbl[idx_i];
      cos_d = tbl[cos_idx];
   end
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         sin_q <= '0;
         cos_q <= '0;
      end else if (en_i) begin
         sin_q <= sin_d;
         cos_q <= cos_d;
      end
   end

   assign sin_o = sin_q;
   assign cos_o = cos_q;

endmodule

// File: rtl/lfo_sched.sv
// lfo_sched: time-multiplexed multi-channel sine/cosine LFO sharing one ROM and one phase adder.
//   clk, rst          : clock, synchronous active-high reset
//   cfg_we/ch/inc/en  : per-channel config write (increment, enable), accepted every cycle
//   cfg_phase_clr     : with cfg_we, zero the addressed channel's phase
//   tick              : start one sweep over enabled channels in ascending order
//   out_valid/ready   : sample stream handshake; out_ch/out_sin/out_cos held until accepted
//   busy              : sweep in progress
//   overrun           : sticky, a tick arrived while busy (cleared only by rst)
// Build option LFO_QUARTER_WAVE_EN selects the quarter-wave ROM inside lfo_sine_rom.
module lfo_sched
   import lfo_pkg::*;
#(
   parameter  int unsigned NUM_CH      = 4,
   parameter  int unsigned WIDTH       = DefWidth,
   parameter  int unsigned PHASE_WIDTH = DefPhaseWidth,
   parameter  int unsigned LUT_BITS    = DefLutBits,
   localparam int unsigned CHW         = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    cfg_we,
   input  logic [CHW-1:0]          cfg_ch,
   input  logic [PHASE_WIDTH-1:0]  cfg_inc,
   input  logic                    cfg_en,
   input  logic                    cfg_phase_clr,
   input  logic                    tick,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [CHW-1:0]          out_ch,
   output logic signed [WIDTH-1:0] out_sin,
   output logic signed [WIDTH-1:0] out_cos,
   output logic                    busy,
   output logic                    overrun
);

   logic [PHASE_WIDTH-1:0] phase_q [NUM_CH];
   logic [PHASE_WIDTH-1:0] inc_q   [NUM_CH];
   logic [NUM_CH-1:0]      en_q;

   lfo_state_e     state_q;
   logic [CHW-1:0] cur_ch_q;
   logic [CHW-1:0] out_ch_q;
   logic           out_valid_q;
   logic           busy_q;
   logic           overrun_q;

   logic [CHW-1:0]         first_ch, next_ch;
   logic                   first_found, next_found;
   logic [PHASE_WIDTH-1:0] phase_sum;
   logic [LUT_BITS-1:0]    lut_idx;
   logic                   lookup;
   logic                   cfg_hit;

   assign lookup    = (state_q == StLookup);
   assign phase_sum = phase_q[cur_ch_q] + inc_q[cur_ch_q];
   assign lut_idx   = phase_q[cur_ch_q][PHASE_WIDTH-1 -: LUT_BITS];
   assign cfg_hit   = cfg_we && (32'(cfg_ch) < NUM_CH);

   // Lowest enabled channel overall, and lowest enabled channel above the current one.
   always_comb begin
      first_found = 1'b0;
      first_ch    = '0;
      next_found  = 1'b0;
      next_ch     = '0;
      for (int i = int'(NUM_CH) - 1; i >= 0; i--) begin
         if (en_q[i]) begin
            first_found = 1'b1;
            first_ch    = CHW'(i);
            if (i > int'(cur_ch_q)) begin
               next_found = 1'b1;
               next_ch    = CHW'(i);
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < int'(NUM_CH); i++) begin
            phase_q[i] <= '0;
            inc_q[i]   <= '0;
         end
         en_q <= '0;
      end else begin
         // Sweep write first, so a coincident config clear on the same channel overrides it.
         if (lookup) phase_q[cur_ch_q] <= phase_sum;
         if (cfg_hit) begin
            inc_q[cfg_ch] <= cfg_inc;
            en_q[cfg_ch]  <= cfg_en;
            if (cfg_phase_clr) phase_q[cfg_ch] <= '0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= StIdle;
         cur_ch_q    <= '0;
         out_ch_q    <= '0;
         out_valid_q <= 1'b0;
         busy_q      <= 1'b0;
         overrun_q   <= 1'b0;
      end else begin
         if (tick && busy_q) overrun_q <= 1'b1;
         unique case (state_q)
            StIdle: begin
               if (tick && first_found) begin
                  state_q  <= StLookup;
                  cur_ch_q <= first_ch;
                  busy_q   <= 1'b1;
               end
            end
            StLookup: begin
               state_q     <= StOutput;
               out_valid_q <= 1'b1;
               out_ch_q    <= cur_ch_q;
            end
            StOutput: begin
               if (out_ready) begin
                  out_valid_q <= 1'b0;
                  if (next_found) begin
                     state_q  <= StLookup;
                     cur_ch_q <= next_ch;
                  end else begin
                     state_q <= StIdle;
                     busy_q  <= 1'b0;
                  end
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   lfo_sine_rom #(
      .WIDTH    (WIDTH),
      .LUT_BITS (LUT_BITS)
   ) u_rom (
      .clk   (clk),
      .rst   (rst),
      .en_i  (lookup),
      .idx_i (lut_idx),
      .sin_o (out_sin),
      .cos_o (out_cos)
   );

   assign out_valid = out_valid_q;
   assign out_ch    = out_ch_q;
   assign busy      = busy_q;
   assign overrun   = overrun_q;

endmodule
